// File: rtl/i2c_ball_slave.sv
// Write-only I2C responder that receives the ball-transfer frame from the master board.
// Drives SDA open-drain for ACK only and commits the payload atomically on a clean STOP.
module i2c_ball_slave #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h12,
  parameter int unsigned NUM_BYTES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [9:0] ball_y,
  output logic [7:0] ball_vy,
  output logic [1:0] gravity_counter,
  output logic [7:0] safe_speed,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(NUM_BYTES + 1);
  localparam int unsigned IdxW = $clog2(NUM_BYTES);
  localparam logic [CntW-1:0] FullCnt = CntW'(NUM_BYTES);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StData,
    StDataAck,
    StIgnore
  } state_e;

  state_e          state_q;
  logic            scl_s1_q, scl_s2_q, scl_h_q;
  logic            sda_s1_q, sda_s2_q, sda_h_q;
  logic [6:0]      shift_q;
  logic [2:0]      bit_cnt_q;
  logic [CntW-1:0] byte_cnt_q;
  logic            fall_seen_q;
  logic            ack_en_q;
  logic            sda_low_q;
  logic            overrun_q;
  logic [7:0]      staging_q [NUM_BYTES];

  logic       start_det, stop_det, scl_rise, scl_fall;
  logic [7:0] rx_byte;

  // Reset gates the driver directly so SDA is released in the same instant.
  assign SDA = (sda_low_q && !reset) ? 1'b0 : 1'bz;

  always_comb begin
    start_det = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
    stop_det  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
    scl_rise  = scl_s2_q & ~scl_h_q;
    scl_fall  = ~scl_s2_q & scl_h_q;
    rx_byte   = {shift_q, sda_s2_q};
  end

  // byte0[5:2] carries no field.
  logic unused_pad;
  assign unused_pad = ^staging_q[0][5:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      scl_s1_q        <= 1'b1;
      scl_s2_q        <= 1'b1;
      scl_h_q         <= 1'b1;
      sda_s1_q        <= 1'b1;
      sda_s2_q        <= 1'b1;
      sda_h_q         <= 1'b1;
      shift_q         <= '0;
      bit_cnt_q       <= '0;
      byte_cnt_q      <= '0;
      fall_seen_q     <= 1'b0;
      ack_en_q        <= 1'b0;
      sda_low_q       <= 1'b0;
      overrun_q       <= 1'b0;
      busy            <= 1'b0;
      frame_valid     <= 1'b0;
      frame_err       <= 1'b0;
      ball_y          <= '0;
      ball_vy         <= '0;
      gravity_counter <= '0;
      safe_speed      <= '0;
      for (int i = 0; i < NUM_BYTES; i++) staging_q[i] <= '0;
    end else begin
      scl_s1_q    <= SCL;
      scl_s2_q    <= scl_s1_q;
      scl_h_q     <= scl_s2_q;
      sda_s1_q    <= SDA;
      sda_s2_q    <= sda_s1_q;
      sda_h_q     <= sda_s2_q;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;

      if (start_det) begin
        state_q     <= StAddr;
        bit_cnt_q   <= '0;
        byte_cnt_q  <= '0;
        fall_seen_q <= 1'b0;
        sda_low_q   <= 1'b0;
        overrun_q   <= 1'b0;
        busy        <= 1'b0;
        frame_err   <= busy;
        for (int i = 0; i < NUM_BYTES; i++) staging_q[i] <= '0;
      end else if (stop_det) begin
        state_q     <= StIdle;
        fall_seen_q <= 1'b0;
        sda_low_q   <= 1'b0;
        overrun_q   <= 1'b0;
        busy        <= 1'b0;
        if (busy) begin
          if (byte_cnt_q == FullCnt && !overrun_q) begin
            gravity_counter <= staging_q[0][7:6];
            ball_y          <= {staging_q[0][1:0], staging_q[1]};
            ball_vy         <= staging_q[2];
            safe_speed      <= staging_q[3];
            frame_valid     <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
      end else begin
        case (state_q)
          StAddr: begin
            if (scl_rise) begin
              shift_q   <= rx_byte[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (rx_byte[7:1] == SLAVE_ADDR && !rx_byte[0]) begin
                  state_q  <= StAddrAck;
                  busy     <= 1'b1;
                  ack_en_q <= 1'b1;
                end else begin
                  state_q <= StIgnore;
                end
              end
            end
          end
          StAddrAck, StDataAck: begin
            // First fall opens the ACK slot, second fall (end of 9th clock) closes it.
            if (scl_fall) begin
              if (!fall_seen_q) begin
                fall_seen_q <= 1'b1;
                sda_low_q   <= ack_en_q;
              end else begin
                fall_seen_q <= 1'b0;
                sda_low_q   <= 1'b0;
                state_q     <= StData;
                if (state_q == StAddrAck) begin
                  byte_cnt_q <= '0;
                end else if (byte_cnt_q < FullCnt) begin
                  byte_cnt_q <= byte_cnt_q + CntW'(1);
                end
              end
            end
          end
          StData: begin
            if (scl_rise) begin
              shift_q   <= rx_byte[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q <= StDataAck;
                if (byte_cnt_q < FullCnt) begin
                  staging_q[byte_cnt_q[IdxW-1:0]] <= rx_byte;
                  ack_en_q <= 1'b1;
                end else begin
                  ack_en_q  <= 1'b0;
                  overrun_q <= 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_ball_slave.md
Name: i2c_ball_slave

Overview:
- I2C write-only responder on the receiving board of the two-board ball-passing game.
- Receives the ball-transfer frame that the master board sends: ball_y, ball_vy, gravity_counter and safe_speed.
- Samples SCL/SDA on the 100 MHz system clock and drives SDA open-drain for ACK.
- Presents the fields as stable registers plus a one-cycle frame_valid strobe to the slave-side game controller.

Parameters:
- SLAVE_ADDR, 7'h12: 7-bit address this block responds to.
- NUM_BYTES, 4: payload bytes per frame; a frame commits only on exactly this count.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high reset.
- SCL  input  1  I2C clock from the master; no clock stretching.
- SDA  inout  1  I2C data, open-drain; driven 1'b0 or 1'bz only, never 1.
- ball_y  output  10  received ball vertical position.
- ball_vy  output  8  received vertical velocity.
- gravity_counter  output  2  received gravity phase.
- safe_speed  output  8  received horizontal speed.
- frame_valid  output  1  1-clk pulse when new fields are committed.
- frame_err  output  1  1-clk pulse when an addressed frame is discarded.
- busy  output  1  high from an address match until STOP or abort.

Behaviour:
- Reset:
  - All outputs 0; SDA released (z); FSM in IDLE.
  - Reset mid-frame releases SDA immediately (asynchronous) and discards the partial frame.
- Input conditioning:
  - SCL and SDA each pass through a 2-flop synchroniser plus one history flop.
  - Edges and conditions are decoded from the synchronised signals only.
- Condition decode:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - Data bits are sampled on the SCL rising edge, MSB first.
- FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE -> ADDR on START.
  - ADDR: shift 8 bits.
    - If {addr[6:0]} == SLAVE_ADDR and R/W == 0: go to ADDR_ACK and set busy.
    - Otherwise: go to IGNORE with no ACK. A matching address with R/W == 1 also goes to IGNORE with no ACK; reads are unsupported.
  - ADDR_ACK:
    - On the SCL falling edge after the 8th bit, drive SDA low.
    - Release SDA on the next SCL falling edge (after the 9th clock), then go to DATA with byte_cnt = 0.
  - DATA:
    - Shift 8 bits into a shift register.
    - After the 8th rising edge, store the byte in staging slot byte_cnt.
    - If byte_cnt < NUM_BYTES: ACK as in ADDR_ACK. Otherwise: NACK (leave SDA released) and set the overrun flag.
  - DATA_ACK:
    - Increment byte_cnt (saturating at NUM_BYTES) and return to DATA.
  - IGNORE: wait for STOP or START; SDA never driven.
- STOP handling (any state -> IDLE):
  - If busy, byte_cnt == NUM_BYTES and no overrun: commit staging to the outputs and pulse frame_valid.
  - Else if busy: pulse frame_err and leave the outputs unchanged.
  - busy clears in the same cycle.
  - The pulse occurs in the cycle after STOP is decoded, at most 4 clk after the SDA edge at the pin.
- Repeated START in any state:
  - Discard staging.
  - If busy, pulse frame_err.
  - Clear busy and overrun, release SDA, go to ADDR.
- Payload mapping, committed atomically so all fields update in the same cycle:
  - byte0 = {gravity_counter[1:0], 4'b0, ball_y[9:8]}
  - byte1 = ball_y[7:0]
  - byte2 = ball_vy
  - byte3 = safe_speed
  - byte0[5:2] are ignored.
- Simultaneous events:
  - START/STOP decode takes priority over bit sampling in the same cycle.
  - SCL edges are never coincident with SDA edges by I2C rule; if both toggle in one sample, the SCL edge is processed and the SDA change is treated as data.
- Timing support: SCL up to 400 kHz; SDA hold at the master of at least 300 ns is met by sampling at 100 MHz.

Test Plan:
- Valid frame:
  - Stimulus: START, 0x24 (addr 0x12, W), 0x82, 0x34, 0x56, 0x78, STOP.
  - Required: ACK on all 5 bytes; ball_y = 0x234, gravity_counter = 2, ball_vy = 0x56, safe_speed = 0x78; frame_valid high exactly 1 clk; busy low after.
- Wrong address:
  - Stimulus: START, 0x26 (addr 0x13), 4 bytes, STOP.
  - Required: SDA never driven low; no frame_valid or frame_err; outputs unchanged.
- Read request:
  - Stimulus: START, 0x25, STOP.
  - Required: NACK; busy stays 0; outputs unchanged.
- Short and long frames:
  - Stimulus: 3 payload bytes then STOP.
  - Required: frame_err pulse; outputs unchanged.
  - Stimulus: 5 payload bytes then STOP.
  - Required: 5th byte NACKed; frame_err pulse; no commit.
- Repeated START:
  - Stimulus: after 2 payload bytes, repeated START, then a full valid frame 0x24, 0x01, 0xFF, 0x10, 0x20, STOP.
  - Required: frame_err once; then ball_y = 0x1FF, gravity_counter = 0, ball_vy = 0x10, safe_speed = 0x20, with frame_valid.
- Reset mid-ACK:
  - Stimulus: assert reset while SDA is held low during ADDR_ACK.
  - Required: SDA = z within the same cycle; all outputs 0; the next valid frame is received normally.
